dec_ex0_issue: RTL

DEC_EX0_ISSUE -- requirements
Module: dec_ex0_issue

---
 rtl/dec_ex0_issue.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/dec_ex0_issue.sv
//==============================================================================
// dec_ex0_issue : 2-entry in-order decode-to-Ex0 issue buffer with illegal-op
//                 counter. Optional operand forwarding: define DEC_EX0_FWD_EN.
// Revision      : 1.0  initial release
//==============================================================================
`default_nettype none

module dec_ex0_issue #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             iValid,
    output logic             oReady,
    input  logic [2:0]       iOp,
    input  logic [31:0]      iS1,
    input  logic [31:0]      iS2,
    input  logic [4:0]       iRs1,
    input  logic [4:0]       iRs2,
    input  logic [4:0]       iRd,
    input  logic             iFlush,
    output logic             oValid,
    input  logic             iExReady,
    output logic [31:0]      oDeS1,
    output logic [31:0]      oDeS2,
    output logic             oDeS1Sign,
    output logic             oDeS2Sign,
    output logic [4:0]       oBitOpEn,
    output logic [4:0]       oRd,
    input  logic [31:0]      iExResult,
    output logic [CNT_W-1:0] oIllegalCnt
);

    typedef struct packed {
        logic [31:0] s1;
        logic [31:0] s2;
        logic        s1_sign;
        logic        s2_sign;
        logic [4:0]  bit_op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        is_slt;
    } entry_t;

    entry_t             head_q, head_d;
    entry_t             tail_q, tail_d;
    entry_t             w_new;
    entry_t             w_new_f;
    entry_t             w_tail_f;
    logic [1:0]         cnt_q, cnt_d;
    logic [CNT_W-1:0]   ill_q, ill_d;
    logic               w_valid;
    logic               w_ready;
    logic               w_accept;
    logic               w_push;
    logic               w_pop;
    logic               w_illegal;
    logic               w_unused;

    assign w_valid   = (cnt_q != 2'd0);
    assign w_ready   = (cnt_q < 2'd2);
    assign w_accept  = iValid && w_ready && !iFlush;
    assign w_push    = w_accept && (iOp <= 3'd5);
    assign w_illegal = w_accept && (iOp > 3'd5);
    assign w_pop     = w_valid && iExReady && !iFlush;

    // Decode happens once, at enqueue, so the head entry drives Ex0 directly.
    always_comb begin
        w_new     = '0;
        w_new.s1  = iS1;
        w_new.s2  = iS2;
        w_new.rd  = iRd;
        w_new.rs1 = iRs1;
        w_new.rs2 = iRs2;
        case (iOp)
            3'd0:    w_new.bit_op = 5'b00001;
            3'd1:    w_new.bit_op = 5'b00010;
            3'd2:    w_new.bit_op = 5'b00100;
            3'd3:    w_new.bit_op = 5'b01000;
            3'd4: begin
                w_new.bit_op  = 5'b10000;
                w_new.is_slt  = 1'b1;
                w_new.s1_sign = iS1[31];
                w_new.s2_sign = iS2[31];
            end
            3'd5:    w_new.bit_op = 5'b10000;
            default: w_new.bit_op = 5'b00000;
        endcase
    end

`ifdef DEC_EX0_FWD_EN
    // Replace operands that read the register the departing head writes.
    function automatic entry_t fwd(input entry_t e, input logic en,
                                   input logic [4:0] rd, input logic [31:0] res);
        entry_t r;
        r = e;
        if (en && (rd != 5'd0)) begin
            if (e.rs1 == rd) begin
                r.s1 = res;
                if (e.is_slt) r.s1_sign = res[31];
            end
            if (e.rs2 == rd) begin
                r.s2 = res;
                if (e.is_slt) r.s2_sign = res[31];
            end
        end
        return r;
    endfunction

    assign w_new_f  = fwd(w_new,  w_pop, head_q.rd, iExResult);
    assign w_tail_f = fwd(tail_q, w_pop, head_q.rd, iExResult);
    assign w_unused = ^{head_q.rs1, head_q.rs2, head_q.is_slt};
`else
    assign w_new_f  = w_new;
    assign w_tail_f = tail_q;
    assign w_unused = ^{head_q.rs1, head_q.rs2, head_q.is_slt, iExResult};
`endif

    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        cnt_d  = cnt_q;
        ill_d  = ill_q;
        if (iFlush) begin
            cnt_d = 2'd0;
        end else begin
            if (w_illegal && (ill_q != {CNT_W{1'b1}}))
                ill_d = ill_q + CNT_W'(1);
            case ({w_pop, w_push})
                2'b11: head_d = w_new_f;
                2'b10: begin
                    head_d = w_tail_f;
                    cnt_d  = cnt_q - 2'd1;
                end
                2'b01: begin
                    if (cnt_q == 2'd0) head_d = w_new_f;
                    else               tail_d = w_new_f;
                    cnt_d = cnt_q + 2'd1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= 2'd0;
            ill_q  <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            cnt_q  <= cnt_d;
            ill_q  <= ill_d;
        end
    end

    assign oReady      = w_ready;
    assign oValid      = w_valid;
    assign oDeS1       = w_valid ? head_q.s1      : 32'd0;
    assign oDeS2       = w_valid ? head_q.s2      : 32'd0;
    assign oDeS1Sign   = w_valid ? head_q.s1_sign : 1'b0;
    assign oDeS2Sign   = w_valid ? head_q.s2_sign : 1'b0;
    assign oBitOpEn    = w_valid ? head_q.bit_op  : 5'd0;
    assign oRd         = w_valid ? head_q.rd      : 5'd0;
    assign oIllegalCnt = ill_q;

endmodule

`default_nettype wire
